cluster_clock_switch_ctrl: RTL and testbench



---
 rtl/cluster_clk_pkg.sv | 28 ++
 rtl/cluster_clock_switch_timer.sv | 41 ++++
 rtl/cluster_clock_switch_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cluster_clock_switch_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_clk_pkg.sv
// ---------------------------------------------------------------------------
// cluster_clk_pkg
// Shared definitions for the cluster clock switch sequencer: the FSM state
// type, counter widths and a saturating increment helper used by the optional
// switch counter (enabled with the CLK_SWITCH_CNT_EN macro).
// ---------------------------------------------------------------------------
package cluster_clk_pkg;

    localparam int CLK_SW_CNT_W = 8;
    localparam int SWITCH_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        GATE_OFF,
        SWITCH,
        SETTLE,
        DONE
    } clk_sw_state_e;

    // Increment that holds at all-ones instead of wrapping to zero.
    function automatic logic [SWITCH_CNT_W-1:0] satInc(input logic [SWITCH_CNT_W-1:0] value);
        if (value == {SWITCH_CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/cluster_clock_switch_timer.sv
// ---------------------------------------------------------------------------
// cluster_clock_switch_timer
// Loadable down-counter with a zero flag. The sequencer loads it on entry to
// the gate-off and settle phases and decrements it while waiting.
//
// Ports:
//   clk          always-on clock
//   rst_n        asynchronous active-low reset (count returns to 0)
//   i_load       load i_load_val (has priority over i_dec)
//   i_load_val   value to load
//   i_dec        decrement by one; holds at zero
//   o_zero       high when the count is zero
// ---------------------------------------------------------------------------
module cluster_clock_switch_timer
    import cluster_clk_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [CLK_SW_CNT_W-1:0] i_load_val,
    input  logic                    i_dec,
    output logic                    o_zero
);

    logic [CLK_SW_CNT_W-1:0] r_count;

    // Load wins over decrement; decrement stops at zero so the count never
    // wraps even if the controller keeps asking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/cluster_clock_switch_ctrl.sv
// ---------------------------------------------------------------------------
// cluster_clock_switch_ctrl
// Sequencer for the cluster 2:1 clock mux and its clock gate. On a request to
// a different source it gates the cluster clock off, waits GATE_WAIT cycles,
// moves the mux select, waits SETTLE_WAIT cycles, re-enables the gate and
// pulses ack_o. A request for the already-selected source acks without
// touching the gate. All outputs are registered.
//
// Optional feature macro: CLK_SWITCH_CNT_EN adds switch_cnt_o, a saturating
// count of completed real source changes.
//
// Ports:
//   clk           always-on controller clock
//   rst_n         asynchronous active-low reset
//   req_i         switch request (level, held until ack_o)
//   sel_i         requested source, stable while req_i is high
//   ack_o         one-cycle completion pulse
//   busy_o        high while a real switch sequence is running
//   clk_en_o      enable to the cluster clock gate
//   clk_sel_o     select to the clock mux
//   cur_sel_o     committed source, updated with ack
//   switch_cnt_o  number of real switches (CLK_SWITCH_CNT_EN only)
// ---------------------------------------------------------------------------
module cluster_clock_switch_ctrl
    import cluster_clk_pkg::*;
#(
    parameter logic DEFAULT_SEL = 1'b0,
    parameter int   GATE_WAIT   = 4,
    parameter int   SETTLE_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    input  logic                    sel_i,
    output logic                    ack_o,
    output logic                    busy_o,
    output logic                    clk_en_o,
    output logic                    clk_sel_o,
`ifdef CLK_SWITCH_CNT_EN
    output logic [SWITCH_CNT_W-1:0] switch_cnt_o,
`endif
    output logic                    cur_sel_o
);

    localparam logic [CLK_SW_CNT_W-1:0] GATE_LOAD   = CLK_SW_CNT_W'(GATE_WAIT - 1);
    localparam logic [CLK_SW_CNT_W-1:0] SETTLE_LOAD = CLK_SW_CNT_W'(SETTLE_WAIT - 1);

    clk_sw_state_e r_state;
    clk_sw_state_e w_state_next;

    logic r_ack;
    logic r_busy;
    logic r_clk_en;
    logic r_clk_sel;
    logic r_cur_sel;
    logic r_tgt_sel;

    logic w_ack_next;
    logic w_busy_next;
    logic w_clk_en_next;
    logic w_clk_sel_next;
    logic w_cur_sel_next;
    logic w_tgt_sel_next;

    logic                    w_tmr_load;
    logic [CLK_SW_CNT_W-1:0] w_tmr_load_val;
    logic                    w_tmr_dec;
    logic                    w_tmr_zero;

`ifdef CLK_SWITCH_CNT_EN
    logic [SWITCH_CNT_W-1:0] r_switch_cnt;
    logic [SWITCH_CNT_W-1:0] w_switch_cnt_next;
`endif

    cluster_clock_switch_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Inputs are only looked at in IDLE; once a sequence
    // starts it runs to completion on the latched target.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_state_next = (sel_i == r_cur_sel) ? DONE : GATE_OFF;
                end
            end
            GATE_OFF: begin
                if (w_tmr_zero) begin
                    w_state_next = SWITCH;
                end
            end
            SWITCH:   w_state_next = SETTLE;
            SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_next = DONE;
                end
            end
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Output/datapath logic: next values for the registered outputs and the
    // timer controls. The select only moves in SWITCH, which sits strictly
    // inside the window where the gate is held off.
    always_comb begin
        w_ack_next     = 1'b0;
        w_busy_next    = r_busy;
        w_clk_en_next  = r_clk_en;
        w_clk_sel_next = r_clk_sel;
        w_cur_sel_next = r_cur_sel;
        w_tgt_sel_next = r_tgt_sel;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = GATE_LOAD;
        w_tmr_dec      = 1'b0;
`ifdef CLK_SWITCH_CNT_EN
        w_switch_cnt_next = r_switch_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (req_i && (sel_i != r_cur_sel)) begin
                    w_tgt_sel_next = sel_i;
                    w_clk_en_next  = 1'b0;
                    w_busy_next    = 1'b1;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = GATE_LOAD;
                end
            end
            GATE_OFF: begin
                w_tmr_dec = !w_tmr_zero;
            end
            SWITCH: begin
                w_clk_sel_next = r_tgt_sel;
                w_tmr_load     = 1'b1;
                w_tmr_load_val = SETTLE_LOAD;
            end
            SETTLE: begin
                if (w_tmr_zero) begin
                    w_clk_en_next = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            DONE: begin
                w_ack_next     = 1'b1;
                w_cur_sel_next = r_clk_sel;
                w_busy_next    = 1'b0;
`ifdef CLK_SWITCH_CNT_EN
                // A mux select that differs from the committed source means
                // this ack closes a real switch, not a no-op.
                if (r_clk_sel != r_cur_sel) begin
                    w_switch_cnt_next = satInc(r_switch_cnt);
                end
`endif
            end
            default: begin
                w_ack_next = 1'b0;
            end
        endcase
    end

    // Output registers; reset puts the gate on and the mux on DEFAULT_SEL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_clk_en  <= 1'b1;
            r_clk_sel <= DEFAULT_SEL;
            r_cur_sel <= DEFAULT_SEL;
            r_tgt_sel <= DEFAULT_SEL;
        end else begin
            r_ack     <= w_ack_next;
            r_busy    <= w_busy_next;
            r_clk_en  <= w_clk_en_next;
            r_clk_sel <= w_clk_sel_next;
            r_cur_sel <= w_cur_sel_next;
            r_tgt_sel <= w_tgt_sel_next;
        end
    end

`ifdef CLK_SWITCH_CNT_EN
    // Saturating count of real switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_switch_cnt <= '0;
        end else begin
            r_switch_cnt <= w_switch_cnt_next;
        end
    end

    assign switch_cnt_o = r_switch_cnt;
`endif

    assign ack_o     = r_ack;
    assign busy_o    = r_busy;
    assign clk_en_o  = r_clk_en;
    assign clk_sel_o = r_clk_sel;
    assign cur_sel_o = r_cur_sel;

endmodule

// File: tb/tb_cluster_clock_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cluster_clock_switch_ctrl
// Directed bench for cluster_clock_switch_ctrl with default parameters
// (DEFAULT_SEL=0, GATE_WAIT=4, SETTLE_WAIT=8). Cycle index k counts clock
// edges from the edge where IDLE samples req_i (k=0); outputs are observed
// 1ns after each edge. For a real switch: clk_en_o is 0 for k=0..12,
// clk_sel_o changes from k=5, busy_o is 1 for k=0..13, ack_o is 1 at k=14.
// Build with CLK_SWITCH_CNT_EN defined to also exercise switch_cnt_o.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cluster_clock_switch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_i = 1'b0;
    logic sel_i = 1'b0;
    logic ack_o;
    logic busy_o;
    logic clk_en_o;
    logic clk_sel_o;
    logic cur_sel_o;
`ifdef CLK_SWITCH_CNT_EN
    logic [15:0] switch_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    cluster_clock_switch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .sel_i        (sel_i),
        .ack_o        (ack_o),
        .busy_o       (busy_o),
        .clk_en_o     (clk_en_o),
        .clk_sel_o    (clk_sel_o),
`ifdef CLK_SWITCH_CNT_EN
        .switch_cnt_o (switch_cnt_o),
`endif
        .cur_sel_o    (cur_sel_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one full request and waits (bounded) for its ack.
    task automatic doRequest(input logic s);
        bit got;
        got = 1'b0;
        req_i = 1'b1;
        sel_i = s;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (ack_o === 1'b1) got = 1'b1;
        end
        req_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL req_timeout: ack_o=0 after 40 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = 1'b0;
        sel_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        checks += 5;
        if (clk_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_clk_sel: got %b, required 0", clk_sel_o); end
        if (clk_en_o  !== 1'b1) begin errors++; $display("[TB] FAIL rst_clk_en: got %b, required 1", clk_en_o); end
        if (busy_o    !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy_o); end
        if (ack_o     !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack: got %b, required 0", ack_o); end
        if (cur_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_cur_sel: got %b, required 0", cur_sel_o); end
`ifdef CLK_SWITCH_CNT_EN
        checks++;
        if (switch_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL rst_cnt: got %0d, required 0", switch_cnt_o); end
`endif
        // Start a 0->1 switch and reset it in the middle of SETTLE.
        req_i = 1'b1;
        sel_i = 1'b1;
        for (int k = 0; k <= 8; k++) step();
        checks += 2;
        if (clk_sel_o !== 1'b1) begin errors++; $display("[TB] FAIL settle_clk_sel: got %b, required 1", clk_sel_o); end
        if (clk_en_o  !== 1'b0) begin errors++; $display("[TB] FAIL settle_clk_en: got %b, required 0", clk_en_o); end
        #3 rst_n = 1'b0;
        #1;
        checks += 5;
        if (clk_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_clk_sel: got %b, required 0", clk_sel_o); end
        if (clk_en_o  !== 1'b1) begin errors++; $display("[TB] FAIL async_rst_clk_en: got %b, required 1", clk_en_o); end
        if (busy_o    !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_busy: got %b, required 0", busy_o); end
        if (ack_o     !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_ack: got %b, required 0", ack_o); end
        if (cur_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_cur_sel: got %b, required 0", cur_sel_o); end
        req_i = 1'b0;
        sel_i = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    // Current source is 0; ask for 0 again.
    task automatic test_noop();
        req_i = 1'b1;
        sel_i = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            step();
            if (k == 1) req_i = 1'b0;
            checks += 3;
            if (ack_o !== (k == 1)) begin errors++; $display("[TB] FAIL noop_ack k=%0d: got %b, required %b", k, ack_o, (k == 1)); end
            if (clk_en_o !== 1'b1) begin errors++; $display("[TB] FAIL noop_clk_en k=%0d: got %b, required 1", k, clk_en_o); end
            if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL noop_busy k=%0d: got %b, required 0", k, busy_o); end
        end
    endtask

    task automatic test_real_switch();
        logic expEn, expSel, expAck, expBusy, expCur;
        req_i = 1'b1;
        sel_i = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            step();
            expEn   = !(k <= 12);
            expSel  = (k >= 5);
            expAck  = (k == 14);
            expBusy = (k <= 13);
            expCur  = (k >= 14);
            checks += 5;
            if (clk_en_o  !== expEn)   begin errors++; $display("[TB] FAIL sw_clk_en k=%0d: got %b, required %b", k, clk_en_o, expEn); end
            if (clk_sel_o !== expSel)  begin errors++; $display("[TB] FAIL sw_clk_sel k=%0d: got %b, required %b", k, clk_sel_o, expSel); end
            if (ack_o     !== expAck)  begin errors++; $display("[TB] FAIL sw_ack k=%0d: got %b, required %b", k, ack_o, expAck); end
            if (busy_o    !== expBusy) begin errors++; $display("[TB] FAIL sw_busy k=%0d: got %b, required %b", k, busy_o, expBusy); end
            if (cur_sel_o !== expCur)  begin errors++; $display("[TB] FAIL sw_cur_sel k=%0d: got %b, required %b", k, cur_sel_o, expCur); end
            if (k == 14) req_i = 1'b0;
        end
    endtask

    // Current source is 1; request 0 then wiggle req_i/sel_i mid-sequence.
    task automatic test_ignore();
        int acks;
        acks = 0;
        req_i = 1'b1;
        sel_i = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            step();
            if (ack_o === 1'b1) acks++;
            if (k == 5) begin
                checks++;
                if (clk_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL ign_clk_sel_flip: got %b, required 0", clk_sel_o); end
            end
            if (k == 1) begin sel_i = 1'b1; req_i = 1'b0; end
            if (k == 2) req_i = 1'b1;
            if (k == 3) req_i = 1'b0;
        end
        checks += 4;
        if (acks !== 1)         begin errors++; $display("[TB] FAIL ign_ack_count: got %0d, required 1", acks); end
        if (clk_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL ign_clk_sel: got %b, required 0", clk_sel_o); end
        if (cur_sel_o !== 1'b0) begin errors++; $display("[TB] FAIL ign_cur_sel: got %b, required 0", cur_sel_o); end
        if (clk_en_o  !== 1'b1) begin errors++; $display("[TB] FAIL ign_clk_en: got %b, required 1", clk_en_o); end
        sel_i = 1'b0;
    endtask

    // Requester holds req_i one cycle past ack: a second, no-op ack follows.
    task automatic test_back_to_back();
        int acks;
        acks = 0;
        req_i = 1'b1;
        sel_i = 1'b1;
        for (int k = 0; k <= 19; k++) begin
            step();
            if (ack_o === 1'b1) acks++;
            if (k == 14 || k == 16) begin
                checks++;
                if (ack_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack k=%0d: got %b, required 1", k, ack_o); end
            end
            if (k >= 13) begin
                checks++;
                if (clk_en_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_clk_en k=%0d: got %b, required 1", k, clk_en_o); end
            end
            if (k == 15) req_i = 1'b0;
        end
        checks += 2;
        if (acks !== 2)         begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d, required 2", acks); end
        if (cur_sel_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_cur_sel: got %b, required 1", cur_sel_o); end
    endtask

    // Random requests; every cycle the select may only move with the gate off.
    task automatic test_random();
        logic prevSel, prevEn, s;
        bit got;
        int gap;
        prevSel = clk_sel_o;
        prevEn  = clk_en_o;
        for (int n = 0; n < 1000; n++) begin
            s = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            got = 1'b0;
            req_i = 1'b1;
            sel_i = s;
            for (int c = 0; c < 40 + gap && !(got && c >= gap + 16); c++) begin
                step();
                if (ack_o === 1'b1) begin
                    got = 1'b1;
                    req_i = 1'b0;
                end
                checks++;
                if ((clk_sel_o !== prevSel) && ((clk_en_o !== 1'b0) || (prevEn !== 1'b0))) begin
                    errors++;
                    $display("[TB] FAIL rnd_sel_while_en n=%0d: sel %b->%b with clk_en %b->%b, required clk_en 0", n, prevSel, clk_sel_o, prevEn, clk_en_o);
                end
                prevSel = clk_sel_o;
                prevEn  = clk_en_o;
            end
            req_i = 1'b0;
            checks += 2;
            if (!got) begin errors++; $display("[TB] FAIL rnd_timeout n=%0d: ack_o never 1, required 1", n); end
            if (cur_sel_o !== s) begin errors++; $display("[TB] FAIL rnd_cur_sel n=%0d: got %b, required %b", n, cur_sel_o, s); end
        end
    endtask

`ifdef CLK_SWITCH_CNT_EN
    task automatic test_count();
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
        step();
        doRequest(1'b1);
        step();
        doRequest(1'b1);
        step();
        doRequest(1'b0);
        step();
        doRequest(1'b0);
        step();
        doRequest(1'b1);
        step();
        checks++;
        if (switch_cnt_o !== 16'd3) begin errors++; $display("[TB] FAIL cnt_three: got %0d, required 3", switch_cnt_o); end
        force dut.r_switch_cnt = 16'hFFFF;
        step();
        release dut.r_switch_cnt;
        doRequest(1'b0);
        step();
        checks++;
        if (switch_cnt_o !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_saturate: got %h, required ffff", switch_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_noop();
        test_real_switch();
        test_ignore();
        test_back_to_back();
        test_random();
`ifdef CLK_SWITCH_CNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
